// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm trigger slice: FSM state encoding,
// time constants and a setpoint range check.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } alarm_state_e;

   localparam int SEC_PER_MIN = 60;
   localparam int SNZ_CNT_W   = 16;

   localparam logic [5:0] HOURS_PER_DAY = 6'd24;
   localparam logic [5:0] MIN_PER_HOUR  = 6'd60;

   // True when hour/minute form a legal 24h time of day.
   function automatic logic time_valid(input logic [5:0] hour, input logic [5:0] minute);
      return (hour < HOURS_PER_DAY) && (minute < MIN_PER_HOUR);
   endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector; RST_VAL sets the assumed previous level after
// reset so a level already high at release can be masked.
module edge_rise #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic d_r;

   // Previous-cycle copy of d, forced to RST_VAL while reset is low.
   always_ff @(posedge clk) begin
      if (!reset) begin
         d_r <= RST_VAL;
      end else begin
         d_r <= d;
      end
   end

   assign rise = d & ~d_r;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm decision logic: detects the start of the alarm minute and runs the
// ring/snooze/stop state machine driving the buzzer and status outputs.
module alarm_trigger
   import alarm_pkg::*;
#(
   parameter int SNOOZE_MIN       = 5,
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int MAX_SNOOZE       = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       sec_tick,
   input  logic [5:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] alarm_hour,
   input  logic [5:0] alarm_min,
   input  logic       snooze,
   input  logic       stop,
   output logic       ringing,
   output logic       buzzer,
   output logic       snoozing,
   output logic [1:0] snooze_count
);

   localparam int RING_W = (RING_TIMEOUT_SEC > 1) ? $clog2(RING_TIMEOUT_SEC) : 1;
   localparam logic [RING_W-1:0]    RING_LAST = RING_W'(RING_TIMEOUT_SEC - 1);
   localparam logic [SNZ_CNT_W-1:0] SNZ_LAST  = SNZ_CNT_W'(SNOOZE_MIN * SEC_PER_MIN - 1);
   localparam logic [1:0]           SNZ_MAX   = 2'(MAX_SNOOZE);

   alarm_state_e         state_r;
   logic [RING_W-1:0]    ring_sec_r;
   logic [SNZ_CNT_W-1:0] snz_sec_r;
   logic                 tone_r;

   logic match_s;
   logic match_rise_s;
   logic snooze_rise_s;
   logic stop_rise_s;

   // An out-of-range setpoint can never equal a legal time, so it never fires.
   assign match_s = time_valid(alarm_hour, alarm_min) &&
                    (cur_hour == alarm_hour) && (cur_min == alarm_min);

   edge_rise #(.RST_VAL(1'b1)) u_match_edge (
      .clk   (clk),
      .reset (reset),
      .d     (match_s),
      .rise  (match_rise_s)
   );

   edge_rise #(.RST_VAL(1'b0)) u_snooze_edge (
      .clk   (clk),
      .reset (reset),
      .d     (snooze),
      .rise  (snooze_rise_s)
   );

   edge_rise #(.RST_VAL(1'b0)) u_stop_edge (
      .clk   (clk),
      .reset (reset),
      .d     (stop),
      .rise  (stop_rise_s)
   );

   // Ring/snooze/stop state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= IDLE;
         ring_sec_r   <= '0;
         snz_sec_r    <= '0;
         tone_r       <= 1'b0;
         snooze_count <= 2'd0;
         ringing      <= 1'b0;
         buzzer       <= 1'b0;
         snoozing     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (enable && match_rise_s) begin
                  state_r      <= RINGING;
                  ring_sec_r   <= '0;
                  snooze_count <= 2'd0;
                  tone_r       <= 1'b1;
                  ringing      <= 1'b1;
                  buzzer       <= 1'b1;
                  snoozing     <= 1'b0;
               end else begin
                  ringing  <= 1'b0;
                  buzzer   <= 1'b0;
                  snoozing <= 1'b0;
               end
            end

            RINGING: begin
               if (!enable || stop_rise_s) begin
                  state_r  <= IDLE;
                  ringing  <= 1'b0;
                  buzzer   <= 1'b0;
                  snoozing <= 1'b0;
               end else if (snooze_rise_s && (snooze_count < SNZ_MAX)) begin
                  state_r      <= SNOOZE;
                  snooze_count <= snooze_count + 2'd1;
                  snz_sec_r    <= '0;
                  ringing      <= 1'b0;
                  buzzer       <= 1'b0;
                  snoozing     <= 1'b1;
               end else if (sec_tick && (ring_sec_r == RING_LAST)) begin
                  state_r  <= IDLE;
                  ringing  <= 1'b0;
                  buzzer   <= 1'b0;
                  snoozing <= 1'b0;
               end else if (sec_tick) begin
                  if (ring_sec_r != '1) begin
                     ring_sec_r <= ring_sec_r + RING_W'(1);
                  end else begin
                     ring_sec_r <= ring_sec_r;
                  end
                  tone_r <= ~tone_r;
                  buzzer <= ~tone_r;
               end else begin
                  buzzer <= tone_r;
               end
            end

            SNOOZE: begin
               if (!enable || stop_rise_s) begin
                  state_r  <= IDLE;
                  ringing  <= 1'b0;
                  buzzer   <= 1'b0;
                  snoozing <= 1'b0;
               end else if (sec_tick && (snz_sec_r == SNZ_LAST)) begin
                  state_r    <= RINGING;
                  ring_sec_r <= '0;
                  tone_r     <= 1'b1;
                  ringing    <= 1'b1;
                  buzzer     <= 1'b1;
                  snoozing   <= 1'b0;
               end else if (sec_tick) begin
                  if (snz_sec_r != '1) begin
                     snz_sec_r <= snz_sec_r + SNZ_CNT_W'(1);
                  end else begin
                     snz_sec_r <= snz_sec_r;
                  end
               end else begin
                  snoozing <= 1'b1;
               end
            end

            default: begin
               state_r  <= IDLE;
               ringing  <= 1'b0;
               buzzer   <= 1'b0;
               snoozing <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences (snooze cycles, limit, timeout, reset).
module tb_alarm_trigger;

   logic       clk = 1'b0;
   logic       reset, enable, sec_tick, snooze, stop;
   logic [5:0] cur_hour, cur_min, alarm_hour, alarm_min;
   logic       ringing, buzzer, snoozing;
   logic [1:0] snooze_count;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alarm_trigger dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .sec_tick     (sec_tick),
      .cur_hour     (cur_hour),
      .cur_min      (cur_min),
      .alarm_hour   (alarm_hour),
      .alarm_min    (alarm_min),
      .snooze       (snooze),
      .stop         (stop),
      .ringing      (ringing),
      .buzzer       (buzzer),
      .snoozing     (snoozing),
      .snooze_count (snooze_count)
   );

   typedef struct {
      logic       rst_n;
      logic       en;
      logic       tick;
      logic [5:0] ch, cm, ah, am;
      logic       snz, stp;
      logic       e_ring, e_buz, e_snzg;
      logic [1:0] e_cnt;
      string      name;
   } vec_t;

   localparam int NV = 20;
   vec_t tbl[NV];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic er, input logic eb,
                        input logic es, input logic [1:0] ec);
      n_vec++;
      if ({ringing, buzzer, snoozing, snooze_count} !== {er, eb, es, ec}) begin
         n_bad++;
         $display("FAIL %s: got ring=%0b buz=%0b snz=%0b cnt=%0d, want ring=%0b buz=%0b snz=%0b cnt=%0d",
                  name, ringing, buzzer, snoozing, snooze_count, er, eb, es, ec);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; enable = 1'b1; sec_tick = 1'b0; snooze = 1'b0; stop = 1'b0;
      alarm_hour = 6'd7; alarm_min = 6'd30; cur_hour = 6'd7; cur_min = 6'd29;
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic trigger();
      cur_hour = 6'd7; cur_min = 6'd29;
      step();
      cur_min = 6'd30;
      step();
      check("trigger", 1'b1, 1'b1, 1'b0, 2'd0);
   endtask

   task automatic ticks(input int n);
      sec_tick = 1'b1;
      repeat (n) step();
      sec_tick = 1'b0;
   endtask

   task automatic snooze_pulse(input logic [1:0] exp_cnt);
      snooze = 1'b1;
      step();
      check("snooze_press", 1'b0, 1'b0, 1'b1, exp_cnt);
      snooze = 1'b0;
      step();
      check("snooze_release", 1'b0, 1'b0, 1'b1, exp_cnt);
   endtask

   initial begin
      // rst_n en tick  ch     cm      ah     am     snz   stp    ring  buz   snzg  cnt
      tbl[0]  = '{1'b0,1'b1,1'b0,6'd7, 6'd29,6'd7,6'd30,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,"reset"};
      tbl[1]  = '{1'b1,1'b1,1'b0,6'd7, 6'd29,6'd7,6'd30,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,"idle_pre"};
      tbl[2]  = '{1'b1,1'b1,1'b0,6'd7, 6'd30,6'd7,6'd30,1'b0,1'b0, 1'b1,1'b1,1'b0,2'd0,"trigger"};
      tbl[3]  = '{1'b1,1'b1,1'b1,6'd7, 6'd30,6'd7,6'd30,1'b0,1'b0, 1'b1,1'b0,1'b0,2'd0,"tone_off"};
      tbl[4]  = '{1'b1,1'b1,1'b0,6'd7, 6'd30,6'd7,6'd30,1'b0,1'b0, 1'b1,1'b0,1'b0,2'd0,"tone_hold"};
      tbl[5]  = '{1'b1,1'b1,1'b1,6'd7, 6'd30,6'd7,6'd30,1'b0,1'b0, 1'b1,1'b1,1'b0,2'd0,"tone_on"};
      tbl[6]  = '{1'b1,1'b1,1'b0,6'd7, 6'd30,6'd7,6'd30,1'b1,1'b0, 1'b0,1'b0,1'b1,2'd1,"snooze"};
      tbl[7]  = '{1'b1,1'b1,1'b0,6'd7, 6'd30,6'd7,6'd30,1'b1,1'b0, 1'b0,1'b0,1'b1,2'd1,"snooze_held"};
      tbl[8]  = '{1'b1,1'b1,1'b0,6'd7, 6'd30,6'd7,6'd30,1'b0,1'b1, 1'b0,1'b0,1'b0,2'd1,"stop"};
      tbl[9]  = '{1'b1,1'b1,1'b0,6'd7, 6'd30,6'd7,6'd30,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd1,"no_retrig"};
      tbl[10] = '{1'b1,1'b1,1'b0,6'd7, 6'd31,6'd7,6'd30,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd1,"idle_31"};
      tbl[11] = '{1'b1,1'b1,1'b0,6'd25,6'd31,6'd25,6'd31,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,"bad_hour"};
      tbl[12] = '{1'b1,1'b1,1'b0,6'd7, 6'd60,6'd7,6'd60,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd1,"bad_min"};
      tbl[13] = '{1'b1,1'b1,1'b0,6'd7, 6'd31,6'd7,6'd32,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd1,"idle_pre2"};
      tbl[14] = '{1'b1,1'b1,1'b0,6'd7, 6'd32,6'd7,6'd32,1'b0,1'b0, 1'b1,1'b1,1'b0,2'd0,"trigger2"};
      tbl[15] = '{1'b1,1'b0,1'b0,6'd7, 6'd32,6'd7,6'd32,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,"disarm_ring"};
      tbl[16] = '{1'b1,1'b1,1'b0,6'd7, 6'd32,6'd7,6'd32,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,"rearm_in_match"};
      tbl[17] = '{1'b1,1'b0,1'b0,6'd7, 6'd33,6'd7,6'd32,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,"disarmed_idle"};
      tbl[18] = '{1'b1,1'b0,1'b0,6'd7, 6'd32,6'd7,6'd32,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,"disarmed_rise"};
      tbl[19] = '{1'b1,1'b1,1'b0,6'd7, 6'd32,6'd7,6'd32,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,"late_enable"};

      reset = 1'b0; enable = 1'b0; sec_tick = 1'b0; snooze = 1'b0; stop = 1'b0;
      cur_hour = 6'd0; cur_min = 6'd0; alarm_hour = 6'd0; alarm_min = 6'd0;
      step();

      for (int i = 0; i < NV; i++) begin
         reset      = tbl[i].rst_n;
         enable     = tbl[i].en;
         sec_tick   = tbl[i].tick;
         cur_hour   = tbl[i].ch;
         cur_min    = tbl[i].cm;
         alarm_hour = tbl[i].ah;
         alarm_min  = tbl[i].am;
         snooze     = tbl[i].snz;
         stop       = tbl[i].stp;
         step();
         check(tbl[i].name, tbl[i].e_ring, tbl[i].e_buz, tbl[i].e_snzg, tbl[i].e_cnt);
      end

      // Three full snooze cycles, then a fourth press at the limit, then stop.
      do_reset();
      trigger();
      for (int k = 1; k <= 3; k++) begin
         snooze_pulse(2'(k));
         ticks(299);
         check("snooze_299", 1'b0, 1'b0, 1'b1, 2'(k));
         ticks(1);
         check("snooze_end", 1'b1, 1'b1, 1'b0, 2'(k));
      end
      snooze = 1'b1;
      step();
      check("snooze_limit", 1'b1, 1'b1, 1'b0, 2'd3);
      snooze = 1'b0;
      stop = 1'b1;
      step();
      check("stop_at_limit", 1'b0, 1'b0, 1'b0, 2'd3);
      stop = 1'b0;
      step();

      // Unattended ringing times out on the 60th tick and does not retrigger.
      trigger();
      ticks(59);
      check("ring_59", 1'b1, 1'b0, 1'b0, 2'd0);
      ticks(1);
      check("timeout", 1'b0, 1'b0, 1'b0, 2'd0);
      repeat (3) step();
      check("no_retrig_timeout", 1'b0, 1'b0, 1'b0, 2'd0);

      // Stop and snooze rising together: stop wins, count unchanged.
      trigger();
      snooze_pulse(2'd1);
      ticks(300);
      check("rering", 1'b1, 1'b1, 1'b0, 2'd1);
      snooze = 1'b1;
      stop = 1'b1;
      step();
      check("stop_beats_snooze", 1'b0, 1'b0, 1'b0, 2'd1);
      snooze = 1'b0;
      stop = 1'b0;
      step();

      // Disarm during snooze.
      trigger();
      snooze_pulse(2'd1);
      enable = 1'b0;
      step();
      check("disarm_snooze", 1'b0, 1'b0, 1'b0, 2'd1);
      enable = 1'b1;
      step();

      // Reset mid-ring, release inside the matching minute, then next day.
      trigger();
      snooze_pulse(2'd1);
      ticks(300);
      check("pre_reset_ring", 1'b1, 1'b1, 1'b0, 2'd1);
      reset = 1'b0;
      step();
      check("reset_mid_ring", 1'b0, 1'b0, 1'b0, 2'd0);
      reset = 1'b1;
      repeat (3) step();
      check("release_in_match", 1'b0, 1'b0, 1'b0, 2'd0);
      cur_min = 6'd31;
      step();
      cur_min = 6'd30;
      step();
      check("next_day", 1'b1, 1'b1, 1'b0, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
- Consumer side of the time-load path: takes the alarm setpoint produced by the hour/minute loader and the running time-of-day, and decides when the alarm sounds.
- Runs a ring/snooze/stop state machine and drives the buzzer and status LEDs.
- Sits between the alarm-setpoint loader, the timekeeping counter (time and 1 Hz tick) and the board's debounced snooze/stop buttons.

Parameters:
- SNOOZE_MIN, 5, snooze duration in minutes (counted as SNOOZE_MIN*60 sec_tick pulses).
- RING_TIMEOUT_SEC, 60, seconds of unattended ringing before auto-off.
- MAX_SNOOZE, 3, maximum snoozes per alarm event (1..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (reset=0 resets on the next clk edge).
- enable  in  1  alarm armed. Low forces IDLE.
- sec_tick  in  1  one-clk pulse per second from the timekeeper.
- cur_hour  in  6  current hour, 24h binary, 0..23.
- cur_min  in  6  current minute, binary, 0..59.
- alarm_hour  in  6  alarm hour from the loader, 24h binary.
- alarm_min  in  6  alarm minute from the loader, binary.
- snooze  in  1  debounced snooze button, level.
- stop  in  1  debounced stop button, level.
- ringing  out  1  state==RINGING.
- buzzer  out  1  beep output, 1 s on / 1 s off while ringing.
- snoozing  out  1  state==SNOOZE.
- snooze_count  out  2  snoozes used in the current event.

Behaviour:
- Reset (reset=0 at clk edge):
  - state=IDLE; ringing, buzzer, snoozing and snooze_count all 0; counters 0.
  - match_d=1, so releasing reset inside the matching minute does not trigger.
- Match detection:
  - match = (cur_hour==alarm_hour) && (cur_min==alarm_min). match_d is its registered copy.
  - match_rise = match & ~match_d.
  - Out-of-range setpoints never match, so they never trigger.
- Button edges: snooze_rise and stop_rise are rising edges against registered copies. Holding a button acts once.
- Latency: each event acts on the next clk edge. For example, ringing=1 in the first cycle after cur_min changes to the matching value.
- IDLE:
  - enable & match_rise -> RINGING; ring_sec=0, snooze_count=0, tone=1.
- RINGING, priority highest first:
  - ~enable or stop_rise -> IDLE.
  - snooze_rise & snooze_count<MAX_SNOOZE -> SNOOZE; snooze_count++, snz_sec=0.
  - snooze_rise at MAX_SNOOZE is ignored; the alarm keeps ringing.
  - sec_tick & ring_sec==RING_TIMEOUT_SEC-1 -> IDLE (auto-off).
  - Otherwise, on sec_tick: ring_sec++ and tone toggles.
- SNOOZE, priority highest first:
  - ~enable or stop_rise -> IDLE.
  - sec_tick & snz_sec==SNOOZE_MIN*60-1 -> RINGING; ring_sec=0, tone=1.
  - Otherwise, on sec_tick: snz_sec++.
- Conflicting events in one cycle:
  - stop beats snooze; stop and ~enable beat timeout.
  - match_rise outside IDLE is ignored.
  - Setpoint changes while RINGING/SNOOZE have no effect until IDLE.
- Outputs:
  - buzzer = ringing & tone.
  - snooze_count holds its value in IDLE until the next trigger clears it.
- Widths:
  - ring_sec is clog2(RING_TIMEOUT_SEC) bits; snz_sec is 16 bits.
  - Counters saturate; they never wrap.

Decomposition:
- Package alarm_pkg:
  - state enum: IDLE=2'd0, RINGING=2'd1, SNOOZE=2'd2.
  - constants SEC_PER_MIN=60 and SNZ_CNT_W=16.
- Sub-module edge_rise (registered rising-edge detector with a reset-value parameter), instantiated three times: match (reset value 1), snooze and stop (reset value 0).

Test Plan:
1. Trigger and beep: alarm 07:30, enable=1, cur 07:29->07:30 -> ringing=1 on the next edge, buzzer=1; after 1 sec_tick buzzer=0, after 2 sec_ticks buzzer=1.
2. Snooze cycle: ringing, pulse snooze -> snoozing=1, ringing=0, snooze_count=1; after 300 sec_ticks -> ringing=1.
3. Snooze limit: snooze 3 times through full cycles -> snooze_count=3; 4th snooze pulse -> still ringing=1, snooze_count=3; then stop -> IDLE.
4. Timeout, no retrigger: ring with no input -> ringing=0 after the 60th sec_tick; cur stays 07:30 -> no retrigger.
5. Stop priority and disarm:
   - stop and snooze rise in the same cycle -> IDLE, snooze_count unchanged.
   - enable=0 during SNOOZE -> snoozing=0 next edge.
6. Reset handling:
   - reset=0 mid-RINGING -> all outputs 0 next edge.
   - Release reset with cur==alarm -> no ring.
   - Next day 07:30 rise -> rings.
